// File: rtl/instr_encoder_if.sv
// Request/response bus of the RV32I instruction encoder.
// The master drives requests and consumes words; the slave is the encoder.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_class;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;

    modport master (
        output in_valid, in_class, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr
    );

    modport slave (
        input  in_valid, in_class, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr
    );
endinterface

// File: rtl/instr_encoder.sv
// Assembles RV32I instruction words from class + operand fields and buffers
// them in a small FIFO; illegal requests are consumed, flagged and counted.
module instr_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    instr_encoder_if.slave   bus,
    output logic             err_illegal,
    output logic [CNT_W-1:0] illegal_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JAL    = 3'd4,
        CLS_LUI    = 3'd5,
        CLS_AUIPC  = 3'd6,
        CLS_BAD    = 3'd7
    } instr_class_e;

    logic [31:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          in_ready_q;
    logic [31:0]   word;
    logic          illegal;
    logic          accept;
    logic          push;
    logic          pop;
    logic [31:0]   imm;

    assign imm    = bus.in_imm;
    assign accept = bus.in_valid && in_ready_q;
    assign push   = accept && !illegal;
    assign pop    = (count != '0) && bus.out_ready;

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (instr_class_e'(bus.in_class))
            CLS_R:      word = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0110011};
            CLS_LOAD:   word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0000011};
            CLS_STORE:  word = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], 7'b0100011};
            CLS_BRANCH: begin
                word    = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                           imm[4:1], imm[11], 7'b1100011};
                illegal = imm[0] || (bus.in_funct3 == 3'b010) || (bus.in_funct3 == 3'b011);
            end
            CLS_JAL: begin
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, 7'b1101111};
                illegal = imm[0];
            end
            CLS_LUI:    word = {imm[31:12], bus.in_rd, 7'b0110111};
            CLS_AUIPC:  word = {imm[31:12], bus.in_rd, 7'b0010111};
            default:    illegal = 1'b1;
        endcase
    end

    always_comb begin
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Storage is not reset: out_instr is forced to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            in_ready_q    <= 1'b1;
            err_illegal   <= 1'b0;
            illegal_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count       <= count_next;
            in_ready_q  <= (count_next != (AW+1)'(DEPTH));
            err_illegal <= accept && illegal;
            if (accept && illegal && (illegal_count != {CNT_W{1'b1}})) begin
                illegal_count <= illegal_count + 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (count != '0);
    assign bus.out_instr = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases from the encoding
// rules plus randomized traffic against a queue-based reference model.
module tb_instr_encoder;
    localparam int DEPTH = 2;
    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             err_illegal;
    logic [CNT_W-1:0] illegal_count;

    instr_encoder_if bus ();

    instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .err_illegal   (err_illegal),
        .illegal_count (illegal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int unsigned model_q[$];
    bit          model_err;
    int          model_cnt;
    bit          last_accepted;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int unsigned fld(input int unsigned v, input int hi, input int lo);
        return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 1);
    endfunction

    // Reference encoder built from field arithmetic on the RV32I layouts.
    function automatic void encode_ref(input int cls, input int unsigned f3, input int unsigned f7,
                                       input int unsigned rd, input int unsigned rs1, input int unsigned rs2,
                                       input int unsigned imm, output int unsigned w, output bit legal);
        int unsigned regs;
        regs  = (rs2 << 20) + (rs1 << 15) + (f3 << 12);
        legal = 1'b1;
        w     = 0;
        case (cls)
            0: w = (f7 << 25) + regs + (rd << 7) + 51;
            1: w = (fld(imm, 11, 0) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 3;
            2: w = (fld(imm, 11, 5) << 25) + regs + (fld(imm, 4, 0) << 7) + 35;
            3: begin
                w = (fld(imm, 12, 12) << 31) + (fld(imm, 10, 5) << 25) + regs
                    + (fld(imm, 4, 1) << 8) + (fld(imm, 11, 11) << 7) + 99;
                legal = (imm % 2 == 0) && (f3 != 2) && (f3 != 3);
            end
            4: begin
                w = (fld(imm, 20, 20) << 31) + (fld(imm, 10, 1) << 21) + (fld(imm, 11, 11) << 20)
                    + (fld(imm, 19, 12) << 12) + (rd << 7) + 111;
                legal = (imm % 2 == 0);
            end
            5: w = (fld(imm, 31, 12) << 12) + (rd << 7) + 55;
            6: w = (fld(imm, 31, 12) << 12) + (rd << 7) + 23;
            default: legal = 1'b0;
        endcase
    endfunction

    task automatic check_model();
        checkOutput("in_ready", {31'd0, bus.in_ready}, (model_q.size() < DEPTH) ? 32'd1 : 32'd0);
        checkOutput("out_valid", {31'd0, bus.out_valid}, (model_q.size() > 0) ? 32'd1 : 32'd0);
        checkOutput("out_instr", bus.out_instr, (model_q.size() > 0) ? model_q[0] : 32'd0);
        checkOutput("err_illegal", {31'd0, err_illegal}, {31'd0, model_err});
        checkOutput("illegal_count", {{(32-CNT_W){1'b0}}, illegal_count}, model_cnt);
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge, check at the next falling edge.
    task automatic applyStimulus(input bit rstn, input bit valid, input int cls, input int unsigned f3,
                                 input int unsigned f7, input int unsigned rd, input int unsigned rs1,
                                 input int unsigned rs2, input int unsigned imm, input bit oready);
        int unsigned w;
        bit legal;
        bit accept;
        bit do_pop;
        rst_n         = rstn;
        bus.in_valid  = valid;
        bus.in_class  = 3'(cls);
        bus.in_funct3 = 3'(f3);
        bus.in_funct7 = 7'(f7);
        bus.in_rd     = 5'(rd);
        bus.in_rs1    = 5'(rs1);
        bus.in_rs2    = 5'(rs2);
        bus.in_imm    = imm;
        bus.out_ready = oready;
        @(posedge clk);
        if (!rstn) begin
            model_q.delete();
            model_err     = 1'b0;
            model_cnt     = 0;
            last_accepted = 1'b0;
        end else begin
            encode_ref(cls, f3, f7, rd, rs1, rs2, imm, w, legal);
            accept = valid && (model_q.size() < DEPTH);
            do_pop = oready && (model_q.size() > 0);
            if (do_pop) void'(model_q.pop_front());
            if (accept && legal) model_q.push_back(w);
            model_err = accept && !legal;
            if (model_err && model_cnt < CNT_MAX) model_cnt++;
            last_accepted = accept;
        end
        @(negedge clk);
        check_model();
    endtask

    task automatic idle(input bit oready);
        applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 0, 0, 0, oready);
    endtask

    task automatic do_reset();
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    endtask

    initial begin
        int guard;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_class = '0; bus.in_funct3 = '0; bus.in_funct7 = '0;
        bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0; bus.out_ready = 1'b0;
        model_err = 1'b0; model_cnt = 0; last_accepted = 1'b0;
        @(negedge clk);
        do_reset();
        checkOutput("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // Single R-type.
        applyStimulus(1, 1, 0, 0, 0, 3, 1, 2, 0, 0);
        checkOutput("r_word", bus.out_instr, 32'h002081B3);
        idle(1);

        // LOAD then STORE, in order.
        applyStimulus(1, 1, 1, 2, 0, 5, 2, 0, 8, 0);
        checkOutput("load_word", bus.out_instr, 32'h00812283);
        applyStimulus(1, 1, 2, 2, 0, 0, 2, 5, 12, 1);
        checkOutput("store_word", bus.out_instr, 32'h00512623);
        idle(1);

        // BRANCH, JAL, LUI.
        applyStimulus(1, 1, 3, 0, 0, 0, 1, 2, 8, 0);
        checkOutput("branch_word", bus.out_instr, 32'h00208463);
        applyStimulus(1, 1, 4, 0, 0, 1, 0, 0, 16, 1);
        checkOutput("jal_word", bus.out_instr, 32'h010000EF);
        applyStimulus(1, 1, 5, 0, 0, 7, 0, 0, 32'h12345000, 1);
        checkOutput("lui_word", bus.out_instr, 32'h123453B7);
        idle(1);

        // Backpressure: third push is held until the consumer drains.
        applyStimulus(1, 1, 0, 0, 0, 3, 1, 2, 0, 0);
        applyStimulus(1, 1, 1, 2, 0, 5, 2, 0, 8, 0);
        checkOutput("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        applyStimulus(1, 1, 2, 2, 0, 0, 2, 5, 12, 0);
        checkOutput("held_head", bus.out_instr, 32'h002081B3);
        applyStimulus(1, 1, 2, 2, 0, 0, 2, 5, 12, 0);
        checkOutput("held_head_stable", bus.out_instr, 32'h002081B3);
        guard = 0;
        do begin
            applyStimulus(1, 1, 2, 2, 0, 0, 2, 5, 12, 1);
            guard++;
        end while (!last_accepted && guard < 10);
        checkOutput("held_accept_bound", (guard < 10) ? 32'd1 : 32'd0, 32'd1);
        repeat (4) idle(1);

        // Back-to-back illegal requests.
        do_reset();
        applyStimulus(1, 1, 7, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("illegal1_err", {31'd0, err_illegal}, 32'd1);
        applyStimulus(1, 1, 4, 0, 0, 1, 0, 0, 3, 1);
        checkOutput("illegal2_err", {31'd0, err_illegal}, 32'd1);
        checkOutput("illegal_cnt2", {{(32-CNT_W){1'b0}}, illegal_count}, 32'd2);
        checkOutput("illegal_no_word", {31'd0, bus.out_valid}, 32'd0);
        applyStimulus(1, 1, 3, 3, 0, 0, 1, 2, 8, 1);
        idle(1);
        checkOutput("err_drops", {31'd0, err_illegal}, 32'd0);

        // Reset with words buffered.
        applyStimulus(1, 1, 0, 0, 0, 3, 1, 2, 0, 0);
        applyStimulus(1, 1, 6, 0, 0, 4, 0, 0, 32'hABCDE123, 0);
        do_reset();
        checkOutput("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("rst_count", {{(32-CNT_W){1'b0}}, illegal_count}, 32'd0);
        applyStimulus(1, 1, 0, 0, 0, 3, 1, 2, 0, 1);
        checkOutput("post_rst_word", bus.out_instr, 32'h002081B3);
        idle(1);

        // Counter saturation.
        repeat (CNT_MAX + 5) applyStimulus(1, 1, 7, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("count_saturated", {{(32-CNT_W){1'b0}}, illegal_count}, CNT_MAX);
        do_reset();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            int unsigned imm_r;
            imm_r = $urandom;
            if ($urandom_range(0, 1) == 0) imm_r = imm_r & 32'hFFFF_FFFE;
            applyStimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0),
                          $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 127),
                          $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                          imm_r, ($urandom_range(0, 2) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the control-unit decode path: takes an instruction class plus operand fields and assembles the 32-bit RV32I instruction word.
- Covers the seven opcodes the control unit decodes: R-type, LOAD, STORE, BRANCH, JAL, LUI, AUIPC.
- Drives instruction memory preload and test-program generation.
- Buffers encoded words in a small FIFO with valid/ready on both sides; rejects illegal requests and counts them.

Parameters:
DEPTH, 2, output FIFO entries (power of two, >=2)
CNT_W, 8, width of illegal-request counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  request valid
in_ready  out  1  encoder can accept request
in_class  in  3  0=R,1=LOAD,2=STORE,3=BRANCH,4=JAL,5=LUI,6=AUIPC,7=invalid
in_funct3  in  3  funct3 field (R/LOAD/STORE/BRANCH)
in_funct7  in  7  funct7 field (R only)
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_imm  in  32  immediate, byte offset / raw value
out_valid  out  1  encoded word available
out_ready  in  1  consumer accepts word
out_instr  out  32  encoded instruction (FIFO head)
err_illegal  out  1  one-cycle pulse on rejected request
illegal_count  out  CNT_W  saturating count of rejected requests

Behaviour:
- Reset (rst_n=0 at posedge): FIFO emptied; in_ready=1, out_valid=0, out_instr=0, err_illegal=0, illegal_count=0. Reset mid-transfer discards all buffered words with no partial output.
- Accept: in_valid && in_ready at posedge. in_ready = !full, registered, with no combinational path from out_ready.
- Pop: out_valid && out_ready at posedge. out_valid = !empty. out_instr = head entry, stable while out_valid && !out_ready.
- Latency: a word accepted at edge N appears at out_instr/out_valid after edge N when the FIFO was empty.
- Ordering: strict FIFO order.
- Simultaneous push and pop, not full: count unchanged, pointers both advance.
- Full: in_ready=0; in_valid is ignored.
- Pointers wrap modulo DEPTH.
- Encoding (opcodes 0110011, 0000011, 0100011, 1100011, 1101111, 0110111, 0010111):
  - R: funct7|rs2|rs1|f3|rd|op.
  - LOAD: imm[11:0]|rs1|f3|rd|op.
  - STORE: imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
  - BRANCH: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
  - JAL: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
  - LUI/AUIPC: imm[31:12]|rd|op.
  - Immediate bits above each format's range are ignored.
- Illegal requests:
  - Conditions: class 7; BRANCH or JAL with imm[0]=1; BRANCH with funct3 of 010 or 011.
  - Request is consumed (handshake completes) but nothing is pushed.
  - err_illegal is high for exactly the cycle after the accepting edge.
  - illegal_count increments and saturates at all-ones.
- Back-to-back illegal requests produce err_illegal high on consecutive cycles.

Test Plan:
- Reset, then single R request (f7=0, rs2=2, rs1=1, f3=0, rd=3) -> out_valid next cycle, out_instr=0x002081B3; after reset all outputs 0.
- LOAD (imm=8, rs1=2, f3=2, rd=5), then STORE (imm=12, rs2=5, rs1=2, f3=2), out_ready=1 -> 0x00812283 then 0x00512623, in order.
- BRANCH (imm=8, rs1=1, rs2=2, f3=0), JAL (imm=16, rd=1), LUI (imm=0x12345000, rd=7) -> 0x00208463, 0x010000EF, 0x123453B7.
- out_ready=0 with 3 pushes at DEPTH=2 -> in_ready drops after 2nd accept, third held. Release out_ready -> first word stays stable until popped, then all three emerge in order.
- class 7, then JAL imm=3 -> err_illegal high two consecutive cycles, illegal_count=2, out_valid stays 0.
- Assert rst_n=0 with 2 words buffered -> out_valid=0, illegal_count=0, next request encodes normally.
